// File: rtl/round_timer_hud.sv
// Countdown round timer with M:SS seven-segment overlay for the metadata HUD.
// Seconds are derived from startOfFrame pulses; pixel outputs are registered one clock after pixelX/pixelY.
module round_timer_hud #(
   parameter int         FRAMES_PER_SEC = 60,
   parameter int         START_MIN      = 3,
   parameter int         START_SEC      = 0,
   parameter int         WARN_SEC       = 10,
   parameter int         BLINK_FRAMES   = 30,
   parameter int         TOP_LEFT_X     = 256,
   parameter int         TOP_LEFT_Y     = 8,
   parameter logic [7:0] DIGIT_COLOR    = 8'hFF,
   parameter logic [7:0] WARN_COLOR     = 8'hE0
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        startRound,
   input  logic        pause,
   input  logic [10:0] pixelX,
   input  logic [10:0] pixelY,
   output logic        drawingRequestOut,
   output logic [7:0]  RGBOut,
   output logic        timeUp,
   output logic [3:0]  timeMin,
   output logic [2:0]  timeSecT,
   output logic [3:0]  timeSecU
);

   localparam int FC_W = $clog2(FRAMES_PER_SEC + 1);
   localparam int BC_W = $clog2(BLINK_FRAMES + 1);

   localparam logic [3:0] START_M    = 4'(START_MIN);
   localparam logic [2:0] START_T    = 3'(START_SEC / 10);
   localparam logic [3:0] START_U    = 4'(START_SEC % 10);
   localparam bit         START_ZERO = (START_MIN == 0) && (START_SEC == 0);

   typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

   state_t            state, state_next;
   logic              time_up_next;
   logic [FC_W-1:0]   frame_cnt;
   logic [BC_W-1:0]   blink_cnt;
   logic              blink_on;

   logic [9:0]        remaining;
   logic              warn_window;
   logic              tick;
   logic              sec_done;
   logic              expire_now;
   logic              blink_hold;
   logic [3:0]        dec_min;
   logic [2:0]        dec_t;
   logic [3:0]        dec_u;

   // ---------------------------------------------------------------
   // Countdown control
   // ---------------------------------------------------------------
   assign remaining   = 10'(timeMin) * 10'd60 + 10'(timeSecT) * 10'd10 + 10'(timeSecU);
   assign warn_window = (state == RUNNING) && (remaining <= 10'(WARN_SEC));
   assign tick        = (state == RUNNING) && !pause && startOfFrame;
   assign sec_done    = tick && (frame_cnt == FC_W'(FRAMES_PER_SEC - 1));
   assign expire_now  = sec_done && (dec_min == 4'd0) && (dec_t == 3'd0) && (dec_u == 4'd0);
   // Blink state is frozen while paused, including the cycle that enters PAUSED.
   assign blink_hold  = (state == PAUSED) || ((state == RUNNING) && pause);

   always_comb begin
      dec_min = timeMin;
      dec_t   = timeSecT;
      dec_u   = timeSecU;
      if (timeSecU != 4'd0) begin
         dec_u = timeSecU - 4'd1;
      end else begin
         dec_u = 4'd9;
         if (timeSecT != 3'd0) begin
            dec_t = timeSecT - 3'd1;
         end else begin
            dec_t   = 3'd5;
            dec_min = timeMin - 4'd1;
         end
      end
   end

   always_comb begin
      state_next   = state;
      time_up_next = 1'b0;
      if (startRound) begin
         state_next   = START_ZERO ? EXPIRED : RUNNING;
         time_up_next = START_ZERO;
      end else begin
         case (state)
            RUNNING: begin
               if (pause) begin
                  state_next = PAUSED;
               end else if (expire_now) begin
                  state_next   = EXPIRED;
                  time_up_next = 1'b1;
               end
            end
            PAUSED: begin
               if (!pause) state_next = RUNNING;
            end
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state     <= IDLE;
         timeUp    <= 1'b0;
         timeMin   <= START_M;
         timeSecT  <= START_T;
         timeSecU  <= START_U;
         frame_cnt <= '0;
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else begin
         state  <= state_next;
         timeUp <= time_up_next;
         if (startRound) begin
            timeMin   <= START_M;
            timeSecT  <= START_T;
            timeSecU  <= START_U;
            frame_cnt <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
         end else begin
            if (tick) begin
               if (sec_done) begin
                  frame_cnt <= '0;
                  timeMin   <= dec_min;
                  timeSecT  <= dec_t;
                  timeSecU  <= dec_u;
               end else begin
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end
            if (!blink_hold) begin
               if (!warn_window || expire_now) begin
                  blink_cnt <= '0;
                  blink_on  <= 1'b1;
               end else if (tick) begin
                  if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                     blink_cnt <= '0;
                     blink_on  <= !blink_on;
                  end else begin
                     blink_cnt <= blink_cnt + 1'b1;
                  end
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Readout rendering: slots are min(16) colon(8) secT(16) secU(16)
   // ---------------------------------------------------------------
   function automatic logic [6:0] seg_map(input logic [3:0] d);
      // bit order {g,f,e,d,c,b,a}
      case (d)
         4'd0:    seg_map = 7'b0111111;
         4'd1:    seg_map = 7'b0000110;
         4'd2:    seg_map = 7'b1011011;
         4'd3:    seg_map = 7'b1001111;
         4'd4:    seg_map = 7'b1100110;
         4'd5:    seg_map = 7'b1101101;
         4'd6:    seg_map = 7'b1111101;
         4'd7:    seg_map = 7'b0000111;
         4'd8:    seg_map = 7'b1111111;
         4'd9:    seg_map = 7'b1101111;
         default: seg_map = 7'b0000000;
      endcase
   endfunction

   function automatic logic seg_lit(input logic [6:0] segs, input logic [3:0] x, input logic [4:0] y);
      logic top_half;
      top_half = (y <= 5'd15);
      seg_lit  = (segs[0] && (y <= 5'd2))
              || (segs[1] && (x >= 4'd13) && top_half)
              || (segs[2] && (x >= 4'd13) && !top_half)
              || (segs[3] && (y >= 5'd29))
              || (segs[4] && (x <= 4'd2) && !top_half)
              || (segs[5] && (x <= 4'd2) && top_half)
              || (segs[6] && (y >= 5'd14) && (y <= 5'd16));
   endfunction

   logic [10:0] dx;
   logic [10:0] dy;
   logic        in_box;
   logic        is_colon;
   logic [3:0]  digit_val;
   logic [3:0]  lx;
   logic [4:0]  ly;
   logic        colon_lit;
   logic        pix_lit;
   logic        draw_next;
   logic [7:0]  rgb_next;

   assign dx     = pixelX - 11'(TOP_LEFT_X);
   assign dy     = pixelY - 11'(TOP_LEFT_Y);
   assign in_box = (pixelX >= 11'(TOP_LEFT_X)) && (pixelY >= 11'(TOP_LEFT_Y))
                && (dx < 11'd56) && (dy < 11'd32);
   assign ly     = dy[4:0];

   always_comb begin
      is_colon  = 1'b0;
      digit_val = timeSecU;
      lx        = 4'(dx - 11'd40);
      if (dx < 11'd16) begin
         digit_val = timeMin;
         lx        = dx[3:0];
      end else if (dx < 11'd24) begin
         is_colon = 1'b1;
         lx       = 4'(dx - 11'd16);
      end else if (dx < 11'd40) begin
         digit_val = {1'b0, timeSecT};
         lx        = 4'(dx - 11'd24);
      end
   end

   assign colon_lit = (lx >= 4'd2) && (lx <= 4'd5)
                   && (((ly >= 5'd8) && (ly <= 5'd11)) || ((ly >= 5'd20) && (ly <= 5'd23)));
   assign pix_lit   = in_box && (is_colon ? colon_lit : seg_lit(seg_map(digit_val), lx, ly));
   assign draw_next = pix_lit && blink_on;
   assign rgb_next  = !draw_next ? 8'h00
                    : ((warn_window || (state == EXPIRED)) ? WARN_COLOR : DIGIT_COLOR);

   always_ff @(posedge clk) begin
      if (!resetN) begin
         drawingRequestOut <= 1'b0;
         RGBOut            <= 8'h00;
      end else begin
         drawingRequestOut <= draw_next;
         RGBOut            <= rgb_next;
      end
   end

endmodule

// File: doc/round_timer_hud.md
Name: round_timer_hud

Overview:
- Countdown round timer with on-screen M:SS readout for the metadata HUD.
- Counts video frames to derive seconds, runs a round state machine, and renders three seven-segment digits plus a colon from the current pixel coordinate.
- Its drawingRequestOut/RGBOut feed the metadata filter stage, whose enable gates it per game mode.
- Its timeUp pulse goes to the game-control FSM.

Parameters:
FRAMES_PER_SEC, 60, startOfFrame pulses per timer second
START_MIN, 3, reload minutes digit (0-9)
START_SEC, 0, reload seconds (0-59)
WARN_SEC, 10, blink and warn colour when total remaining seconds <= this and state RUNNING
BLINK_FRAMES, 30, frames per blink half-period
TOP_LEFT_X, 256, left pixel of the readout
TOP_LEFT_Y, 8, top pixel of the readout
DIGIT_COLOR, 8'hFF, normal RGB332 colour
WARN_COLOR, 8'hE0, warning RGB332 colour

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset
startOfFrame  in  1  one-clk pulse per frame
startRound  in  1  one-clk pulse: reload and run
pause  in  1  level: hold countdown
pixelX  in  11  current pixel column
pixelY  in  11  current pixel row
drawingRequestOut  out  1  pixel belongs to lit readout
RGBOut  out  8  pixel colour, 0 when not drawing
timeUp  out  1  one-clk pulse on expiry
timeMin  out  4  BCD minutes
timeSecT  out  3  BCD seconds tens
timeSecU  out  4  BCD seconds units

Behaviour:
- Reset: one clock and reset for all state. On resetN=0 at a clk edge: state IDLE, digits = START value, frame counter 0, blink counter 0, blinkOn 1, drawingRequestOut 0, RGBOut 0, timeUp 0.
- State IDLE: shows the reload value steady; no counting.
- State RUNNING: frame counter increments on each startOfFrame. When it is FRAMES_PER_SEC-1 and startOfFrame arrives, it clears and the BCD time decrements with borrow:
  - units 0 -> 9 with tens-1
  - tens 0 -> 5 with min-1
- RUNNING -> PAUSED when pause=1. PAUSED -> RUNNING when pause=0. Frame and blink counters hold while PAUSED.
- RUNNING -> EXPIRED: when a decrement produces 0:00, the state becomes EXPIRED on the same edge and timeUp=1 for exactly that one clk.
- EXPIRED: shows 0:00 steady in WARN_COLOR; no further decrement.
- Priority within a cycle: startRound > pause > tick.
  - startRound in any state reloads digits, clears frame and blink counters, sets blinkOn=1 and enters RUNNING.
  - If START is 0:00, startRound enters EXPIRED with a timeUp pulse instead.
  - startRound coincident with a tick: the tick is discarded.
- Blink: only in RUNNING with remaining <= WARN_SEC. The blink counter counts startOfFrame; at BLINK_FRAMES-1 it wraps and blinkOn toggles. Outside the warn window, blinkOn is forced to 1 and the counter is held at 0.
- Readout geometry: four slots starting at TOP_LEFT_X, all 32 rows tall from TOP_LEFT_Y.
  - min: 16 px
  - colon: 8 px
  - secT: 16 px
  - secU: 16 px
  - Total width 56.
- Digit-local coordinates x 0-15, y 0-31. Segments:
  - a: y<=2
  - d: y>=29
  - g: 14<=y<=16
  - f: x<=2 and y<=15
  - b: x>=13 and y<=15
  - e: x<=2 and y>=16
  - c: x>=13 and y>=16
  - Standard 7-seg digit-to-segment encoding; digit 7 = a, b, c.
- Colon-local: lit for x 2-5 with y 8-11 or y 20-23.
- Pixel outputs:
  - Registered; latency exactly 1 clk from pixelX/pixelY.
  - drawingRequestOut=1 iff the pixel is in a lit segment/dot and blinkOn=1.
  - RGBOut = WARN_COLOR if (warn window or EXPIRED), otherwise DIGIT_COLOR, when drawing; 0 otherwise.
- Digit outputs timeMin/timeSecT/timeSecU are direct register values with no extra latency.

Test Plan:
- Reset, then startRound; 180 seconds of startOfFrame pulses (60 per second) -> time steps 3:00, 2:59 ... 0:01, 0:00. timeUp high for exactly 1 clk on the frame-10800 edge. State EXPIRED; further frames leave 0:00.
- After 3:00 -> 2:59, pause=1 for 120 frames, then release -> time still 2:59 throughout the pause; 2:58 arrives 60 frames after release, counting the frame counter value held at pause.
- At 0:10 in RUNNING, sample pixel (TOP_LEFT_X+24+5, TOP_LEFT_Y+1), segment a of the tens digit "1" -> unlit. Sample the units "0" segment a at (TOP_LEFT_X+40+5, TOP_LEFT_Y+1) -> RGBOut=8'hE0 with blinkOn=1, and 0 after 30 frames; toggles every 30 frames.
- IDLE at 3:00, drive pixelX/Y over the colon dot (TOP_LEFT_X+16+3, TOP_LEFT_Y+9) -> the next clk drawingRequestOut=1, RGBOut=8'hFF. Pixel (TOP_LEFT_X+16+3, TOP_LEFT_Y+15) -> 0, 0.
- startRound and startOfFrame on the same clk at frame counter 59 during 1:00 -> time reloads to 3:00 with no decrement; frame counter 0.
- resetN=0 for one clk mid-RUNNING at 1:23 with a lit pixel addressed -> the next edge gives IDLE, 3:00, drawingRequestOut=0, RGBOut=0, timeUp=0.
